// File: rtl/restoring_divider_seq.sv
// -----------------------------------------------------------------------------
// restoring_divider_seq
//   Sequential restoring integer divider. The controller and the datapath live
//   in one block. The divider produces one quotient bit per clock and uses a
//   start/busy/done handshake. It flags divide-by-zero and, in signed builds,
//   the single overflow case.
//
//   Optional build macro: RESTORING_DIVIDER_SIGNED_EN
//     When it is defined, the operands are two's complement and the division
//     truncates toward zero. When it is undefined, the divider is unsigned
//     only and ovf_flag is tied to 0.
//
// Parameters
//   W   operand / quotient / remainder width (W >= 2)
//   CW  step-counter width, derived from W
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   start      request, sampled only in IDLE
//   dividend   dividend, captured on an accepted start
//   divisor    divisor, captured on an accepted start
//   busy       high from the accepting edge until done drops
//   done       one-cycle pulse; the results are valid
//   quotient   quotient, held until the next result load
//   remainder  remainder, held until the next result load
//   dz_flag    the last operation divided by zero
//   ovf_flag   the last operation overflowed (signed builds only)
// -----------------------------------------------------------------------------
module restoring_divider_seq #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz_flag,
  output logic         ovf_flag
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // The partial remainder is stored in W bits. After each step it is smaller
  // than the divisor, so the top bit of the (W+1)-bit P is always zero. That
  // bit only exists in shifted/trial below.
  logic [W-1:0]  p_q, p_d;
  logic [W-1:0]  q_q, q_d;        // dividend shifting out, quotient shifting in
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          zero_q, zero_d;  // captured divisor was zero
  logic          dz_q, dz_d;

  logic [W:0]    shifted, trial;
  logic [W-1:0]  q_step, p_step;
  logic [W-1:0]  fix_q, fix_r;    // final-step results after sign fix-up
  logic [W-1:0]  a_cap, b_cap;    // operand values loaded on start

  // One restoring step: shift {P,Q} left and trial-subtract the divisor.
  assign shifted = {1'b0, p_q, q_q[W-1]};
  assign trial   = shifted - {1'b0, dvs_q};
  assign q_step  = {q_q[W-2:0], ~trial[W]};
  assign p_step  = trial[W] ? shifted[W-1:0] : trial[W-1:0];

`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic ovf_p_q, ovf_p_d, ovf_q, ovf_d;

  // Divide the magnitudes. For a zero divisor, keep the raw dividend, because
  // it becomes the remainder unchanged. -2^(W-1) has no positive counterpart,
  // but its magnitude as an unsigned pattern is still correct. For the
  // overflow case the unsigned core then yields quotient 2^(W-1) and
  // remainder 0 with no sign flip, which is the required result.
  assign b_cap = divisor[W-1] ? (~divisor + 1'b1) : divisor;
  assign a_cap = (divisor == '0) ? dividend
               : (dividend[W-1] ? (~dividend + 1'b1) : dividend);
  assign fix_q = neg_q_q ? (~q_step + 1'b1) : q_step;
  assign fix_r = neg_r_q ? (~p_step + 1'b1) : p_step;
  assign ovf_flag = ovf_q;
`else
  assign a_cap    = dividend;
  assign b_cap    = divisor;
  assign fix_q    = q_step;
  assign fix_r    = p_step;
  assign ovf_flag = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      ovf_p_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
      dz_q    <= dz_d;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      ovf_p_q <= ovf_p_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    zero_d  = zero_q;
    dz_d    = dz_q;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    ovf_p_d = ovf_p_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = a_cap;
          dvs_d   = b_cap;
          p_d     = '0;
          cnt_d   = '0;
          dz_d    = 1'b0;
          zero_d  = (divisor == '0);
          // A zero divisor also spends a single RUN cycle. That cycle loads
          // the flagged result at the next edge, so done follows one cycle
          // later.
          state_d = RUN;
`ifdef RESTORING_DIVIDER_SIGNED_EN
          ovf_d   = 1'b0;
          neg_q_d = dividend[W-1] ^ divisor[W-1];
          neg_r_d = dividend[W-1];
          ovf_p_d = (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
`endif
        end
      end
      RUN: begin
        if (zero_q) begin
          quot_d  = '1;
          rem_d   = q_q;
          dz_d    = 1'b1;
          state_d = DONE;
        end else begin
          p_d   = p_step;
          q_d   = q_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) begin
            quot_d  = fix_q;
            rem_d   = fix_r;
            state_d = DONE;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            ovf_d   = ovf_p_q;
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz_flag   = dz_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider_seq
//   Scoreboarded bench for restoring_divider_seq with W = 8. Each accepted
//   start pushes a model result. A monitor pops one result and compares it on
//   every done pulse. The main thread checks latency, busy, reset behaviour
//   and throughput.
// -----------------------------------------------------------------------------
module tb_restoring_divider_seq;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, dz_flag, ovf_flag;
  logic [W-1:0] quotient, remainder;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  restoring_divider_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz_flag   (dz_flag),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa, sb_i;
    logic [31:0] t;
    e = '0;
    sa = 0; sb_i = 0; t = '0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
`ifdef RESTORING_DIVIDER_SIGNED_EN
      sa = $signed(a);
      sb_i = $signed(b);
      if (sa == -(2 ** (W - 1)) && sb_i == -1) begin
        e.q = {1'b1, {(W-1){1'b0}}}; e.r = '0; e.ovf = 1'b1;
      end else begin
        t = sa / sb_i; e.q = t[W-1:0];
        t = sa % sb_i; e.r = t[W-1:0];
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  // The scoreboard monitor compares every done pulse with the next expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("quotient", quotient, e.q);
        check_eq("remainder", remainder, e.r);
        check_eq("dz_flag", dz_flag, e.dz);
        check_eq("ovf_flag", ovf_flag, e.ovf);
      end
    end
  end

  // Drive one request for one cycle. On return it is #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    dividend = a; divisor = b; start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // This counts edges after the accepting edge until done is seen, with a
  // fixed bound. It also counts the cycles with busy high, starting at the
  // first cycle after the accepting edge.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cycles++;
    end
    if (!done) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat, bc, t_first;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_quot", quotient, 0);
    check_eq("rst_rem", remainder, 0);
    check_eq("rst_dz", dz_flag, 0);
    check_eq("rst_ovf", ovf_flag, 0);
    @(posedge clk); #1; rst = 1'b0;

    // 100/7: done follows W edges after the accepting edge. Busy covers the
    // W RUN cycles plus the DONE cycle.
    start_op(8'd100, 8'd7);
    wait_done(lat, bc);
    check_eq("lat_100_7", lat, W);
    check_eq("busy_cycles_100_7", bc, W + 1);
    @(posedge clk); #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("busy_after_done", busy, 0);
    check_eq("held_quot", quotient, 14);

    // 255/1 then 0/13. The second start is driven the cycle after done.
    start_op(8'd255, 8'd1);
    wait_done(lat, bc);
    t_first = cyc;
    start_op(8'd0, 8'd13);
    wait_done(lat, bc);
    check_eq("b2b_done_spacing", cyc - t_first, W + 2);

    // Divide by zero: done follows a single edge after the accepting edge.
    start_op(8'd5, 8'd0);
    wait_done(lat, bc);
    check_eq("lat_dz", lat, 1);

    // Reset after 4 steps of 100/7. The previous dz result must clear
    // without a clock edge.
    start_op(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_quot", quotient, 0);
    check_eq("arst_rem", remainder, 0);
    check_eq("arst_dz", dz_flag, 0);
    check_eq("arst_busy", busy, 0);
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    start_op(8'd9, 8'd4);
    wait_done(lat, bc);
    check_eq("lat_after_rst", lat, W);

    // Start held high. The operands change right after the capture edge. The
    // first result must stay 200/3. The held start is accepted again W+2
    // cycles later and captures the new operands.
    @(posedge clk); #1;
    dividend = 8'd200; divisor = 8'd3; start = 1'b1;
    sb.push_back(model(8'd200, 8'd3));
    @(posedge clk); #1;
    dividend = 8'd17; divisor = 8'd5;
    sb.push_back(model(8'd17, 8'd5));
    wait_done(lat, bc);
    check_eq("lat_held", lat, W);
    t_first = cyc;
    @(posedge clk); #1;
    wait_done(lat, bc);
    check_eq("held_done_spacing", cyc - t_first, W + 2);
    start = 1'b0;
    @(posedge clk); #1;

`ifdef RESTORING_DIVIDER_SIGNED_EN
    start_op(8'h9C, 8'd7);   // -100 / 7
    wait_done(lat, bc);
    check_eq("lat_signed", lat, W);
    start_op(8'h80, 8'hFF);  // -128 / -1
    wait_done(lat, bc);
    start_op(8'hF9, 8'h00);  // -7 / 0
    wait_done(lat, bc);
`endif

    repeat (4) @(posedge clk);
    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
